// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master: FSM states,
// {cpol,cpha} mode encodings and transfer-length clamping.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    BITS,
    TRAIL,
    GAP
  } state_t;

  // Mode encoding is {cpol, cpha}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int clamp_len(input int len_in, input int data_w);
    return ((len_in == 0) || (len_in > data_w)) ? data_w : len_in;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: down-counter reloaded with the divider value,
// one-cycle tick each time it reaches zero, held in reload while not running.
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = i_run && (r_cnt == '0);

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_run || o_tick) begin
      r_cnt <= i_div;
    end else begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: one word per wrt, all four CPOL/CPHA
// modes, MISO capture into a left-shifting register, decoded chip selects.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 8,
  parameter int NUM_SS = 2,
  localparam int LEN_W = $clog2(DATA_W + 1),
  localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [LEN_W-1:0]  len,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  div,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS_n,
  output logic              SCLK,
  output logic              MOSI,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(2 * DATA_W + 1);

  state_t            r_state, w_next;
  logic              w_tick;
  logic [DIV_W-1:0]  r_div, w_div;
  logic [LEN_W-1:0]  r_len, w_len;
  logic              r_cpha;
  logic [CNT_W-1:0]  r_half, w_half_total;
  logic [DATA_W-1:0] r_shift, w_tx_aligned;
  logic              r_miso_bit;
  logic [NUM_SS-1:0] r_ss_n, w_ss_dec;
  logic              r_sclk, r_mosi, r_busy, r_done;
  logic [DATA_W-1:0] r_rx;
  logic              w_in_bits, w_lead_edge, w_trail_edge, w_final_edge;

  // The counter reloads during IDLE, so it must see the incoming div on the
  // accepting edge, not the previous transfer's latched value.
  assign w_div = (r_state == IDLE) ? div : r_div;

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .i_run (r_state != IDLE),
    .i_div (w_div),
    .o_tick(w_tick)
  );

  assign w_len        = LEN_W'(clamp_len(int'(len), DATA_W));
  assign w_tx_aligned = tx_data << (DATA_W - int'(w_len));
  assign w_half_total = CNT_W'({r_len, 1'b0});

  always_comb begin
    for (int i = 0; i < NUM_SS; i++) begin
      w_ss_dec[i] = (ss_sel != SS_W'(i));
    end
  end

  // Edge k (1-based) fires on the tick ending LEAD or BITS half-period k-1;
  // odd edges lead, even edges trail, and the last BITS half-period has none.
  assign w_in_bits    = w_tick && (r_state == BITS) && (r_half != w_half_total);
  assign w_lead_edge  = (w_tick && (r_state == LEAD)) || (w_in_bits && !r_half[0]);
  assign w_trail_edge = w_in_bits && r_half[0];
  assign w_final_edge = (r_half == w_half_total - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets a default first so no path through the case infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (wrt) w_next = LEAD;
      LEAD:  if (w_tick) w_next = BITS;
      BITS:  if (w_tick && (r_half == w_half_total)) w_next = TRAIL;
      TRAIL: if (w_tick) w_next = GAP;
      GAP:   if (w_tick) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_n     <= '1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_rx       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div      <= '0;
      r_len      <= '0;
      r_cpha     <= 1'b0;
      r_shift    <= '0;
      r_miso_bit <= 1'b0;
      r_half     <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        r_sclk <= cpol;
        r_mosi <= 1'b0;
        if (wrt) begin
          r_div   <= div;
          r_len   <= w_len;
          r_cpha  <= cpha;
          r_shift <= w_tx_aligned;
          r_mosi  <= cpha ? 1'b0 : w_tx_aligned[DATA_W-1];
          r_ss_n  <= w_ss_dec;
          r_busy  <= 1'b1;
        end
      end
      if (w_tick && (r_state == LEAD))      r_half <= CNT_W'(1);
      else if (w_tick && (r_state == BITS)) r_half <= r_half + CNT_W'(1);
      if (w_lead_edge || w_trail_edge) r_sclk <= ~r_sclk;
      if (w_lead_edge) begin
        if (r_cpha) r_mosi     <= r_shift[DATA_W-1];
        else        r_miso_bit <= MISO;
      end
      if (w_trail_edge) begin
        r_shift <= {r_shift[DATA_W-2:0], r_cpha ? MISO : r_miso_bit};
        if (!r_cpha && !w_final_edge) r_mosi <= r_shift[DATA_W-2];
      end
      if (w_tick && (r_state == TRAIL)) r_ss_n <= '1;
      if (w_tick && (r_state == GAP)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_rx   <= r_shift;
        r_mosi <= 1'b0;
      end
    end
  end

  assign SS_n    = r_ss_n;
  assign SCLK    = r_sclk;
  assign MOSI    = r_mosi;
  assign rx_data = r_rx;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: modes 0-3, loopback/tied/slave MISO,
// chip select, back-to-back, mid-transfer reset and length clamping.
module tb_spi_master_param;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrt = 1'b0;
  logic [15:0] tx_data = '0;
  logic [4:0]  len = '0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic [7:0]  div = '0;
  logic [0:0]  ss_sel = '0;
  logic        MISO;
  logic [1:0]  SS_n;
  logic        SCLK, MOSI, busy, done;
  logic [15:0] rx_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // 0: loopback from MOSI, 1: tied high, 2: slave model
  int          miso_mode = 0;
  logic [15:0] slv_word = '0;
  int          slv_len = 1;
  int          slv_k = 0;
  logic        slv_miso = 1'b0;
  logic        slv_sel_d = 1'b0;
  logic        slv_prev = 1'b0;

  spi_master_param #(.DATA_W(16), .DIV_W(8), .NUM_SS(2)) dut (
    .clk(clk), .rst_n(rst_n), .wrt(wrt), .tx_data(tx_data), .len(len),
    .cpol(cpol), .cpha(cpha), .div(div), .ss_sel(ss_sel), .MISO(MISO),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .rx_data(rx_data), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign MISO = (miso_mode == 0) ? MOSI : (miso_mode == 1) ? 1'b1 : slv_miso;

  // Slave: launches a bit on its launch edge, then inverts MISO half a clock
  // after the sample edge so a master sampling on the wrong edge reads garbage.
  always @(negedge clk) begin : slave
    int   k;
    logic lead;
    if (SS_n == 2'b11) begin
      slv_sel_d <= 1'b0;
      slv_miso  <= 1'b0;
    end else if (!slv_sel_d) begin
      slv_sel_d <= 1'b1;
      slv_prev  <= SCLK;
      slv_k     <= cpha ? -1 : 0;
      slv_miso  <= cpha ? 1'b0 : slv_word[slv_len-1];
    end else if (SCLK != slv_prev) begin
      slv_prev <= SCLK;
      lead = (slv_prev == cpol);
      if (cpha ? lead : !lead) begin
        k = slv_k + 1;
        slv_k <= k;
        slv_miso <= (k < slv_len) ? slv_word[slv_len-1-k] : 1'b0;
      end else begin
        slv_miso <= ~slv_miso;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Runs one transfer; mode is set two cycles ahead so SCLK has settled idle.
  task automatic run_xfer(input logic [15:0] t_tx, input logic [4:0] t_len,
                          input logic [1:0] t_mode, input logic [7:0] t_div,
                          input logic [0:0] t_sel, output int done_at,
                          output logic [15:0] rx_got, output int rises,
                          output logic [15:0] lead_bits, output logic [1:0] ss_low,
                          output logic busy_c1, output logic busy_done);
    int   c0;
    logic prev;
    @(negedge clk);
    cpol = t_mode[1];
    cpha = t_mode[0];
    @(negedge clk);
    @(negedge clk);
    tx_data = t_tx; len = t_len; div = t_div; ss_sel = t_sel; wrt = 1'b1;
    c0 = cyc; prev = SCLK;
    done_at = -1; rx_got = '0; rises = 0; lead_bits = '0; ss_low = '0; busy_done = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
    busy_c1 = busy;
    for (int i = 0; i < 3000; i++) begin
      if (SCLK != prev) begin
        if (SCLK) rises++;
        if (prev == t_mode[1]) lead_bits = {lead_bits[14:0], MOSI};
        prev = SCLK;
      end
      ss_low |= ~SS_n;
      if (done) begin
        done_at = cyc - c0;
        rx_got = rx_data;
        busy_done = busy;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (SS_n !== 2'b11) begin failures++; $display("FAIL reset_ss_n: got %b expected 11", SS_n); end
    checks++; if (SCLK !== 1'b0) begin failures++; $display("FAIL reset_sclk: got %b expected 0", SCLK); end
    checks++; if (MOSI !== 1'b0) begin failures++; $display("FAIL reset_mosi: got %b expected 0", MOSI); end
    checks++; if (rx_data !== 16'h0) begin failures++; $display("FAIL reset_rx: got %h expected 0000", rx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0_loopback();
    int d; logic [15:0] rx, lb; int r; logic [1:0] sl; logic b1, bd;
    miso_mode = 0;
    run_xfer(16'hA55A, 5'd16, SPI_MODE0, 8'd7, 1'b0, d, rx, r, lb, sl, b1, bd);
    checks++; if (rx !== 16'hA55A) begin failures++; $display("FAIL mode0_rx: got %h expected a55a", rx); end
    checks++; if (d !== 281) begin failures++; $display("FAIL mode0_done_cycle: got %0d expected 281", d); end
    checks++; if (r !== 16) begin failures++; $display("FAIL mode0_rises: got %0d expected 16", r); end
    checks++; if (lb !== 16'hA55A) begin failures++; $display("FAIL mode0_mosi: got %h expected a55a", lb); end
    checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL mode0_busy_c1: got %b expected 1", b1); end
    checks++; if (bd !== 1'b0) begin failures++; $display("FAIL mode0_busy_done: got %b expected 0", bd); end
    checks++; if (sl !== 2'b01) begin failures++; $display("FAIL mode0_ss: got %b expected 01", sl); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mode0_done_width: got %b expected 0", done); end
  endtask

  task automatic test_mode3_tied();
    int d; logic [15:0] rx, lb; int r; logic [1:0] sl; logic b1, bd;
    miso_mode = 1;
    cpol = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (SCLK !== 1'b1) begin failures++; $display("FAIL mode3_idle_sclk: got %b expected 1", SCLK); end
    run_xfer(16'h00C3, 5'd8, SPI_MODE3, 8'd0, 1'b0, d, rx, r, lb, sl, b1, bd);
    checks++; if (rx !== 16'h00FF) begin failures++; $display("FAIL mode3_rx: got %h expected 00ff", rx); end
    checks++; if (lb[7:0] !== 8'hC3) begin failures++; $display("FAIL mode3_mosi_seq: got %b expected 11000011", lb[7:0]); end
    checks++; if (d !== 20) begin failures++; $display("FAIL mode3_done_cycle: got %0d expected 20", d); end
    checks++; if (SCLK !== 1'b1) begin failures++; $display("FAIL mode3_end_sclk: got %b expected 1", SCLK); end
  endtask

  task automatic test_modes12_slave();
    int d; logic [15:0] rx, lb; int r; logic [1:0] sl; logic b1, bd;
    miso_mode = 2; slv_word = 16'h000A; slv_len = 5;
    run_xfer(16'h0015, 5'd5, SPI_MODE1, 8'd2, 1'b0, d, rx, r, lb, sl, b1, bd);
    checks++; if (rx !== 16'h000A) begin failures++; $display("FAIL mode1_rx: got %h expected 000a", rx); end
    checks++; if (lb[4:0] !== 5'h15) begin failures++; $display("FAIL mode1_mosi: got %h expected 15", lb[4:0]); end
    checks++; if (d !== 40) begin failures++; $display("FAIL mode1_done_cycle: got %0d expected 40", d); end
    run_xfer(16'h0015, 5'd5, SPI_MODE2, 8'd2, 1'b0, d, rx, r, lb, sl, b1, bd);
    checks++; if (rx !== 16'h000A) begin failures++; $display("FAIL mode2_rx: got %h expected 000a", rx); end
    checks++; if (lb[4:0] !== 5'h15) begin failures++; $display("FAIL mode2_mosi: got %h expected 15", lb[4:0]); end
    checks++; if (d !== 40) begin failures++; $display("FAIL mode2_done_cycle: got %0d expected 40", d); end
  endtask

  task automatic test_back_to_back();
    int c0, d1, d2; logic [15:0] rx1, rx2; logic [1:0] sl;
    miso_mode = 0;
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0;
    repeat (2) @(negedge clk);
    tx_data = 16'h0009; len = 5'd4; div = 8'd1; ss_sel = 1'b1; wrt = 1'b1;
    c0 = cyc; d1 = -1; d2 = -1; rx1 = '0; rx2 = '0; sl = '0;
    @(negedge clk);
    wrt = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cyc - c0 == 5) begin
        wrt = 1'b1; tx_data = 16'h000F; len = 5'd8; ss_sel = 1'b0;
      end else begin
        wrt = 1'b0;
      end
      sl |= ~SS_n;
      if (done) begin
        d1 = cyc - c0; rx1 = rx_data;
        break;
      end
      @(negedge clk);
    end
    wrt = 1'b1; tx_data = 16'h0006; len = 5'd4; ss_sel = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_next: got %b expected 1", busy); end
    checks++; if (SS_n !== 2'b01) begin failures++; $display("FAIL b2b_ss_next: got %b expected 01", SS_n); end
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        d2 = cyc - c0; rx2 = rx_data;
        break;
      end
      @(negedge clk);
    end
    checks++; if (d1 !== 23) begin failures++; $display("FAIL b2b_done1_cycle: got %0d expected 23", d1); end
    checks++; if (rx1 !== 16'h0009) begin failures++; $display("FAIL b2b_rx1: got %h expected 0009", rx1); end
    checks++; if (sl !== 2'b10) begin failures++; $display("FAIL b2b_ss_sel1: got %b expected 10", sl); end
    checks++; if (d2 !== 46) begin failures++; $display("FAIL b2b_done2_cycle: got %0d expected 46", d2); end
    checks++; if (rx2 !== 16'h0006) begin failures++; $display("FAIL b2b_rx2: got %h expected 0006", rx2); end
  endtask

  task automatic test_reset_mid();
    int c0, d; logic seen_done; logic [15:0] rx, lb; int r; logic [1:0] sl; logic b1, bd;
    miso_mode = 0;
    @(negedge clk);
    tx_data = 16'hBEEF; len = 5'd16; div = 8'd3; ss_sel = 1'b0; wrt = 1'b1;
    c0 = cyc; seen_done = 1'b0;
    @(negedge clk);
    wrt = 1'b0;
    while (cyc - c0 < 30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (SS_n !== 2'b11) begin failures++; $display("FAIL rstmid_ss_n: got %b expected 11", SS_n); end
    checks++; if (SCLK !== 1'b0) begin failures++; $display("FAIL rstmid_sclk: got %b expected 0", SCLK); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cyc - c0 == 35) rst_n = 1'b1;
      if (done) seen_done = 1'b1;
      if (cyc - c0 >= 160) break;
    end
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL rstmid_no_done: got %b expected 0", seen_done); end
    run_xfer(16'h3C5A, 5'd16, SPI_MODE0, 8'd1, 1'b0, d, rx, r, lb, sl, b1, bd);
    checks++; if (rx !== 16'h3C5A) begin failures++; $display("FAIL rstmid_next_rx: got %h expected 3c5a", rx); end
    checks++; if (d !== 71) begin failures++; $display("FAIL rstmid_next_cycle: got %0d expected 71", d); end
  endtask

  task automatic test_len_bounds();
    int d; logic [15:0] rx, lb; int r; logic [1:0] sl; logic b1, bd;
    miso_mode = 0;
    run_xfer(16'h1234, 5'd0, SPI_MODE0, 8'd0, 1'b0, d, rx, r, lb, sl, b1, bd);
    checks++; if (rx !== 16'h1234) begin failures++; $display("FAIL len0_rx: got %h expected 1234", rx); end
    checks++; if (d !== 36) begin failures++; $display("FAIL len0_done_cycle: got %0d expected 36", d); end
    checks++; if (r !== 16) begin failures++; $display("FAIL len0_rises: got %0d expected 16", r); end
    run_xfer(16'hFFFF, 5'd1, SPI_MODE0, 8'd0, 1'b0, d, rx, r, lb, sl, b1, bd);
    checks++; if (rx !== 16'h0001) begin failures++; $display("FAIL len1_rx: got %h expected 0001", rx); end
    checks++; if (d !== 6) begin failures++; $display("FAIL len1_done_cycle: got %0d expected 6", d); end
    checks++; if (r !== 1) begin failures++; $display("FAIL len1_rises: got %0d expected 1", r); end
  endtask

  initial begin
    test_reset();
    test_mode0_loopback();
    test_mode3_tied();
    test_modes12_slave();
    test_back_to_back();
    test_reset_mid();
    test_len_bounds();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
